riscv_data_bif_ram: RTL
=======================

# riscv_data_bif_ram

Data-side bus responder: a word-organised, byte-writable single-port RAM that answers the `data_bif_*` request/acknowledge protocol driven by the execute pipe's memory stage. It sits on the far end of the core's data bus interface, in place of or alongside external memory. Per transaction it:
- decodes the address window;
- inserts a programmable number of wait states;
- performs the read or byte-masked write;
- returns a single-cycle acknowledge, plus an error flag for out-of-window accesses.

## Interface
Parameters:
- `MEM_AW`, 10: word-address width; capacity 2^MEM_AW 32-bit words.
- `BASE_ADDR`, 32'h0000_0000: byte base of window; aligned to 4·2^MEM_AW.
- `WAIT_CYCLES`, 0: wait states inserted before acknowledge; legal range 0..15.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_bif_req`  in  1  request, level; held by requester until it sees `data_bif_ack`.
- `data_bif_addr`  in  32  byte address; bits [1:0] ignored.
- `data_bif_rnw`  in  1  1 = read, 0 = write.
- `data_bif_wmask`  in  4  byte-lane write enables; bit n writes wdata[8n+7:8n].
- `data_bif_wdata`  in  32  write data.
- `data_bif_rdata`  out  32  read data; valid in the `data_bif_ack` cycle of a read.
- `data_bif_ack`  out  1  one-cycle completion pulse.
- `data_bif_err`  out  1  asserted with `data_bif_ack` when the address is out of window.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset forces IDLE.
- **IDLE**
  - `data_bif_req`=1 accepts a request: capture addr, rnw, wmask, wdata; load the wait counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else the access is performed this edge and the next state is RESP.
  - `data_bif_req`=0: stay in IDLE.
- **WAIT**
  - Counter decrements each cycle.
  - When the counter reaches 1, the access is performed at that edge and the next state is RESP.
  - Inputs are ignored while in WAIT. Dropping req does not abort the transaction; it completes normally.
- **Access**
  - In window means `(addr - BASE_ADDR) < 4·2^MEM_AW`, computed with 32-bit unsigned subtraction so that addresses below base wrap and fail the check.
  - Word index is `(addr - BASE_ADDR)[MEM_AW+1:2]`.
  - In-window read: the memory word is registered into `data_bif_rdata`.
  - In-window write: only the lanes with wmask=1 are updated. wmask=0 still completes with ack and changes nothing.
  - Out of window: no memory update, `data_bif_rdata` is loaded with 0, and the `data_bif_err` register is set.
- **RESP**
  - `data_bif_ack`=1 for exactly this one cycle; the next state is always IDLE.
  - req is ignored in RESP, so a requester still holding req in the ack cycle does not cause a second acceptance.
- `data_bif_rdata` is updated only by read accesses and error accesses. It holds its value otherwise, including across write acks.
- Memory array contents are not reset and are unaffected by `rst`.

## Timing
- Reset values: `data_bif_ack`=0, `data_bif_err`=0, `data_bif_rdata`=32'h0, state=IDLE, counter=0.
- Latency:
  - req high and sampled in IDLE at edge k → ack high during cycle k+1+WAIT_CYCLES.
  - WAIT_CYCLES=0 gives ack in the cycle right after acceptance.
- Throughput: one transaction per 2+WAIT_CYCLES cycles. The earliest next acceptance is at the edge ending the first IDLE cycle after RESP.
- `data_bif_err` is high only in the ack cycle, and only for error transactions.
- All outputs are registered; none depends combinationally on inputs.
- Read-after-write to the same word, back to back, returns the new data (the write completes before the next acceptance).
- `rst` asserted in WAIT or RESP: at the next edge the FSM returns to IDLE, ack=0, err=0, rdata=0, and the pending access is dropped. A write not yet performed leaves memory unchanged.
- `rst` and req high in the same cycle: reset wins and the request is not accepted.

## Test plan
- **Basic write/read, WAIT_CYCLES=0:**
  - write 0x0000_0010, wdata 0xA5A5_1234, wmask 4'hF → ack one cycle after acceptance, err=0;
  - read 0x10 → rdata=0xA5A5_1234 in its ack cycle.
- **Byte masking:**
  - preload 0x1122_3344 at 0x20;
  - write wdata 0xAABB_CCDD, wmask 4'b0101 → read returns 0x11BB_33DD;
  - wmask 4'b0000 → acked, word unchanged.
- **Wait states, WAIT_CYCLES=3:**
  - req accepted at edge k → ack exactly in cycle k+4, single-cycle pulse;
  - req held high through ack → next acceptance no earlier than edge k+5;
  - req dropped during WAIT → ack still issued.
- **Out of window, MEM_AW=10, BASE_ADDR=0x1000:**
  - read 0x2000 → ack with err=1, rdata=0;
  - read 0x0FFC → err=1;
  - write 0x2000 → err=1 and no alias written at 0x1000.
- **Reset mid-transaction, WAIT_CYCLES=3:**
  - assert rst in the second WAIT cycle of a write → ack never asserted, all outputs 0 next cycle;
  - subsequent read of that address returns the old data.
- **Back-to-back stress:**
  - random reads/writes with req continuously high, compared against a reference memory model;
  - check exactly one ack per transaction and rdata matching the model.

Source files
------------

// File: rtl/riscv_data_bif_ram_if.sv
// Data bus interface bundle between the execute pipe's memory stage
// (master) and a data-side responder such as riscv_data_bif_ram (slave).
interface riscv_data_bif_ram_if;
   logic        req;
   logic [31:0] addr;
   logic        rnw;
   logic [3:0]  wmask;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        err;

   modport master (
      output req,
      output addr,
      output rnw,
      output wmask,
      output wdata,
      input  rdata,
      input  ack,
      input  err
   );

   modport slave (
      input  req,
      input  addr,
      input  rnw,
      input  wmask,
      input  wdata,
      output rdata,
      output ack,
      output err
   );
endinterface

// File: rtl/riscv_data_bif_ram.sv
// Word-organised, byte-writable single-port RAM answering the data_bif
// request/acknowledge protocol. It decodes an address window, inserts a
// fixed number of wait states, performs the access and returns a one-cycle
// acknowledge with an error flag for out-of-window accesses.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for req; accepts and captures the request on req=1
// WAIT  | counting down wait states; access happens when the counter is 1
// RESP  | ack (and err) high for this single cycle; always returns to IDLE
module riscv_data_bif_ram #(
   parameter int          MEM_AW      = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   riscv_data_bif_ram_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int          MEM_WORDS = 1 << MEM_AW;
   // Window size kept in 33 bits so a full 4 GiB window cannot wrap to 0.
   localparam logic [32:0] WIN_BYTES = 33'(1) << (MEM_AW + 2);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   logic [1:0]  state;
   logic [3:0]  wait_cnt;

   logic [31:0] addr_q;
   logic        rnw_q;
   logic [3:0]  wmask_q;
   logic [31:0] wdata_q;

   logic        ack_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic [31:0] mem [0:MEM_WORDS-1];

   logic [31:0]       acc_addr;
   logic              acc_rnw;
   logic [3:0]        acc_wmask;
   logic [31:0]       acc_wdata;
   logic [31:0]       acc_offset;
   logic              acc_in_win;
   logic [MEM_AW-1:0] acc_idx;
   logic              do_access;

   // Select the access operands: with zero wait states the access happens on
   // the accepting edge, so the live bus values are used; otherwise the
   // captured copy is used and the bus is ignored.
   always_comb begin
      acc_addr   = addr_q;
      acc_rnw    = rnw_q;
      acc_wmask  = wmask_q;
      acc_wdata  = wdata_q;
      do_access  = 1'b0;
      if (state == ST_IDLE) begin
         acc_addr  = bus.addr;
         acc_rnw   = bus.rnw;
         acc_wmask = bus.wmask;
         acc_wdata = bus.wdata;
         do_access = bus.req && (WAIT_INIT == 4'd0);
      end else if (state == ST_WAIT) begin
         do_access = (wait_cnt == 4'd1);
      end
      if (rst) begin
         do_access = 1'b0;
      end
      // Unsigned wrap makes addresses below the base land far out of window.
      acc_offset = acc_addr - BASE_ADDR;
      acc_in_win = ({1'b0, acc_offset} < WIN_BYTES);
      acc_idx    = acc_offset[MEM_AW+1:2];
   end

   // Sequencing FSM, request capture and registered response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
         addr_q   <= 32'h0;
         rnw_q    <= 1'b0;
         wmask_q  <= 4'h0;
         wdata_q  <= 32'h0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req) begin
                  addr_q   <= bus.addr;
                  rnw_q    <= bus.rnw;
                  wmask_q  <= bus.wmask;
                  wdata_q  <= bus.wdata;
                  wait_cnt <= WAIT_INIT;
                  state    <= (WAIT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         ack_q <= do_access;
         err_q <= do_access && !acc_in_win;
         // Writes leave rdata alone; reads and error accesses reload it.
         if (do_access && (acc_rnw || !acc_in_win)) begin
            rdata_q <= acc_in_win ? mem[acc_idx] : 32'h0;
         end
      end
   end

   // Byte-lane masked write; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (do_access && !acc_rnw && acc_in_win) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (acc_wmask[lane]) begin
               mem[acc_idx][8*lane +: 8] <= acc_wdata[8*lane +: 8];
            end
         end
      end
   end

   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;

endmodule
